// File: rtl/gnn_pkg.sv
// Shared types and sizes for the GNN result drain: lane geometry, result word
// type and drain FSM states.
package gnn_pkg;

  localparam int NUM_NODES     = 4;
  localparam int OUTS_PER_NODE = 2;
  localparam int DW            = 21;
  localparam int L             = NUM_NODES * OUTS_PER_NODE;
  localparam int IDX_W         = $clog2(L);

  typedef logic signed [DW-1:0] res_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    SEND    = 2'd2
  } drain_state_t;

  // A set is complete once every lane has been captured.
  function automatic logic mask_full(input logic [L-1:0] mask);
    return &mask;
  endfunction

endpackage

// File: rtl/gnn_sat_counter.sv
// Saturating event counter: increments by one per flagged cycle and sticks at
// all-ones. Cleared only by the synchronous active-low reset.
module gnn_sat_counter #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Count register with saturation at the top value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= {CNT_W{1'b0}};
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/gnn_result_drain.sv
// Captures one 8-lane GNN result set and streams it out in lane order on a
// valid/ready interface, counting result cycles that arrive while it is full.
module gnn_result_drain
  import gnn_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [L*DW-1:0]       res_data,
  input  logic [L-1:0]          res_vld,
  output logic signed [DW-1:0]  m_data,
  output logic [IDX_W-1:0]      m_idx,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic                  m_last,
  output logic                  busy,
  output logic [CNT_W-1:0]      drop_cnt
);

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;
  logic [L-1:0]     r_mask;
  logic [L-1:0]     w_mask_nxt;
  res_t             r_buf [L];
  res_t             w_buf_nxt [L];
  logic [IDX_W-1:0] r_idx;
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_drop;
  logic             w_xfer;

  res_t             r_m_data;
  logic [IDX_W-1:0] r_m_idx;
  logic             r_m_valid;
  logic             r_m_last;
  logic             r_busy;

  assign w_xfer = r_m_valid & m_ready;

  // Next-state, capture and drop decode for the drain FSM.
  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_buf_nxt   = r_buf;
    w_idx_nxt   = r_idx;
    w_drop      = 1'b0;
    case (r_state)
      IDLE: begin
        for (int k = 0; k < L; k++) begin
          if (res_vld[k]) begin
            w_buf_nxt[k]  = res_data[k*DW +: DW];
            w_mask_nxt[k] = 1'b1;
          end else begin
            w_mask_nxt[k] = r_mask[k];
          end
        end
        if (mask_full(w_mask_nxt)) begin
          w_state_nxt = SEND;
        end else if (|res_vld) begin
          w_state_nxt = COLLECT;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      COLLECT: begin
        // A lane already held is never overwritten; a repeat is a drop.
        for (int k = 0; k < L; k++) begin
          if (res_vld[k] && !r_mask[k]) begin
            w_buf_nxt[k]  = res_data[k*DW +: DW];
            w_mask_nxt[k] = 1'b1;
          end else if (res_vld[k]) begin
            w_drop = 1'b1;
          end else begin
            w_mask_nxt[k] = r_mask[k];
          end
        end
        if (mask_full(w_mask_nxt)) begin
          w_state_nxt = SEND;
        end else begin
          w_state_nxt = COLLECT;
        end
      end
      SEND: begin
        w_drop = |res_vld;
        if (w_xfer && (r_idx == IDX_W'(L-1))) begin
          w_idx_nxt   = {IDX_W{1'b0}};
          w_mask_nxt  = {L{1'b0}};
          w_state_nxt = IDLE;
        end else if (w_xfer) begin
          w_idx_nxt = r_idx + IDX_W'(1);
        end else begin
          w_idx_nxt = r_idx;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_mask_nxt  = {L{1'b0}};
        w_idx_nxt   = {IDX_W{1'b0}};
      end
    endcase
  end

  // State, buffer and registered stream outputs, all computed from next-state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_mask    <= {L{1'b0}};
      r_idx     <= {IDX_W{1'b0}};
      for (int k = 0; k < L; k++) begin
        r_buf[k] <= {DW{1'b0}};
      end
      r_m_data  <= {DW{1'b0}};
      r_m_idx   <= {IDX_W{1'b0}};
      r_m_valid <= 1'b0;
      r_m_last  <= 1'b0;
      r_busy    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_mask    <= w_mask_nxt;
      r_idx     <= w_idx_nxt;
      r_buf     <= w_buf_nxt;
      r_m_data  <= (w_state_nxt == SEND) ? w_buf_nxt[w_idx_nxt] : {DW{1'b0}};
      r_m_idx   <= w_idx_nxt;
      r_m_valid <= (w_state_nxt == SEND);
      r_m_last  <= (w_state_nxt == SEND) && (w_idx_nxt == IDX_W'(L-1));
      r_busy    <= (w_state_nxt != IDLE);
    end
  end

  gnn_sat_counter #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_drop),
    .o_cnt (drop_cnt)
  );

  assign m_data  = r_m_data;
  assign m_idx   = r_m_idx;
  assign m_valid = r_m_valid;
  assign m_last  = r_m_last;
  assign busy    = r_busy;

endmodule
